// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C mux target
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] MUX_ADDR_DEFAULT = 7'h70;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop sync, stability filter and edge detect for one bus line
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iLine,
  output logic oLvl,
  output logic oRise,
  output logic oFall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Idle bus is high, so the filtered level starts released.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      oLvl  <= 1'b1;
      oRise <= 1'b0;
      oFall <= 1'b0;
    end else begin
      s1    <= iLine;
      s2    <= s1;
      oRise <= 1'b0;
      oFall <= 1'b0;
      if (s2 != oLvl) begin
        if (cnt == CW'(FILT - 1)) begin
          oLvl  <= s2;
          oRise <= s2;
          oFall <= ~s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_mux_ctrl_slave.sv
// rtl/i2c_mux_ctrl_slave.sv - I2C target owning the mux channel-select register
module i2c_mux_ctrl_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = MUX_ADDR_DEFAULT,
  parameter int         NCH      = 4,
  parameter int         FILT     = 3
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iSCL,
  input  logic           iSDA,
  output logic           oSDAOE,
  output logic [NCH-1:0] oChSel,
  output logic           oWrStb,
  output logic           oBusy
);

  logic       scl_lvl, scl_rise, scl_fall;
  logic       sda_lvl, sda_rise, sda_fall;
  logic       start_evt, stop_evt;
  logic [7:0] chsel_pad;

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic [7:0] sh;
  logic       rw;
  logic       rd_first;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLine (iSCL),
    .oLvl  (scl_lvl),
    .oRise (scl_rise),
    .oFall (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .iClk  (iClk),
    .iRst  (iRst),
    .iLine (iSDA),
    .oLvl  (sda_lvl),
    .oRise (sda_rise),
    .oFall (sda_fall)
  );

  // Both lines see identical latency, so their relative ordering is preserved.
  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;
  assign chsel_pad = 8'(oChSel);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      byte_full <= 1'b0;
      sh        <= 8'h00;
      rw        <= 1'b0;
      rd_first  <= 1'b0;
      oSDAOE    <= 1'b1;
      oChSel    <= '0;
      oWrStb    <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oWrStb <= 1'b0;
      if (stop_evt) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
        rd_first  <= 1'b0;
        oSDAOE    <= 1'b1;
        oBusy     <= 1'b0;
      end else if (start_evt) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
        rd_first  <= 1'b0;
        oSDAOE    <= 1'b1;
      end else begin
        case (state)
          ST_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              sh      <= {sh[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              byte_full <= 1'b0;
              if (state == ST_ADDR) begin
                if (sh[7:1] == SLV_ADDR) begin
                  rw     <= sh[0];
                  oSDAOE <= I2C_ACK;
                  oBusy  <= 1'b1;
                  state  <= ST_ADDR_ACK;
                end else begin
                  oSDAOE <= 1'b1;
                  state  <= ST_IGNORE;
                end
              end else begin
                oChSel <= sh[NCH-1:0];
                oWrStb <= 1'b1;
                oSDAOE <= I2C_ACK;
                state  <= ST_WR_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!rw) begin
                oSDAOE <= 1'b1;
                state  <= ST_WR_DATA;
              end else begin
                sh     <= chsel_pad;
                oSDAOE <= chsel_pad[7];
                state  <= ST_RD_DATA;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              oSDAOE <= 1'b1;
              state  <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            // Rises count the bits the master has taken; falls present the next one.
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall) begin
              if (rd_first) begin
                rd_first <= 1'b0;
                oSDAOE   <= sh[7];
              end else if (byte_full) begin
                byte_full <= 1'b0;
                oSDAOE    <= 1'b1;
                state     <= ST_RD_ACK;
              end else begin
                oSDAOE <= sh[6];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                sh       <= chsel_pad;
                rd_first <= 1'b1;
                bit_cnt  <= 3'd0;
                state    <= ST_RD_DATA;
              end else begin
                oSDAOE <= 1'b1;
                oBusy  <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mux_ctrl_slave.sv
// tb/tb_i2c_mux_ctrl_slave.sv - bus-master bench with vector table and expectation queue
module tb_i2c_mux_ctrl_slave;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  logic       sda_bus;
  logic       sdaoe;
  logic [3:0] chsel;
  logic       wrstb;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int low_cnt = 0;
  int n_start = 0;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
    logic       exp_ack;
    logic       exp_busy;
    logic [3:0] exp_chsel;
    int         exp_wr;
  } vec_t;
  vec_t vec[8];

  assign sda_bus = msda & sdaoe;

  i2c_mux_ctrl_slave dut (
    .iClk   (clk),
    .iRst   (rst),
    .iSCL   (scl),
    .iSDA   (sda_bus),
    .oSDAOE (sdaoe),
    .oChSel (chsel),
    .oWrStb (wrstb),
    .oBusy  (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrstb) wr_cnt++;
    if (sdaoe === 1'b0) low_cnt++;
    if (dut.start_evt) n_start++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input logic [7:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0x%0h, expected no output", act);
    end else begin
      e = sb.pop_front();
      check(e.nm, 32'(act), 32'(e.v));
    end
  endtask

  task automatic push_exp(input string nm, input logic [7:0] v);
    sb_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic wbit(input logic b);
    msda = b;
    wclk(Q);
    scl = 1'b1;
    wclk(2 * Q);
    scl = 1'b0;
    wclk(Q);
  endtask

  task automatic rbit(output logic b);
    msda = 1'b1;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    b = sda_bus;
    wclk(Q);
    scl = 1'b0;
    wclk(Q);
  endtask

  task automatic start_c();
    msda = 1'b1;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    msda = 1'b0;
    wclk(Q);
    scl = 1'b0;
    wclk(Q);
  endtask

  task automatic stop_c();
    msda = 1'b0;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    msda = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    push_exp(nm, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    pop_check({7'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic mack, input string nm);
    logic [7:0] r;
    logic       b;
    push_exp(nm, exp);
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      r[i] = b;
    end
    pop_check(r);
    wbit(mack);
  endtask

  initial begin
    vec_t v;
    int   wr0, low0, st0;

    vec[0] = '{8'hE0, 8'h05, 1'b0, 1'b0, 1'b1, 4'h5, 1};
    vec[1] = '{8'hE1, 8'h05, 1'b1, 1'b0, 1'b1, 4'h5, 0};
    vec[2] = '{8'hE2, 8'hFF, 1'b0, 1'b1, 1'b0, 4'h5, 0};
    vec[3] = '{8'hE0, 8'h3A, 1'b0, 1'b0, 1'b1, 4'hA, 1};
    vec[4] = '{8'hE1, 8'h0A, 1'b1, 1'b0, 1'b1, 4'hA, 0};
    vec[5] = '{8'hE0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1};
    vec[6] = '{8'hE1, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 0};
    vec[7] = '{8'hE3, 8'hFF, 1'b1, 1'b1, 1'b0, 4'h0, 0};

    wclk(4);
    check("rst_sdaoe", 32'(sdaoe), 32'd1);
    check("rst_chsel", 32'(chsel), 32'd0);
    check("rst_wrstb", 32'(wrstb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wclk(20);

    for (int k = 0; k < 8; k++) begin
      v    = vec[k];
      wr0  = wr_cnt;
      low0 = low_cnt;
      start_c();
      send_byte(v.addr, v.exp_ack, $sformatf("v%0d_addr_ack", k));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'(v.exp_busy));
      if (!v.rd) begin
        send_byte(v.data, v.exp_ack, $sformatf("v%0d_data_ack", k));
      end else begin
        recv_byte(v.data, 1'b1, $sformatf("v%0d_rd_data", k));
        check($sformatf("v%0d_busy_nack", k), 32'(busy), 32'd0);
      end
      stop_c();
      wclk(10);
      check($sformatf("v%0d_busy_stop", k), 32'(busy), 32'd0);
      check($sformatf("v%0d_chsel", k), 32'(chsel), 32'(v.exp_chsel));
      check($sformatf("v%0d_wrstb_cnt", k), 32'(wr_cnt - wr0), 32'(v.exp_wr));
      if (!v.exp_busy) check($sformatf("v%0d_sda_never_low", k), 32'(low_cnt - low0), 32'd0);
    end

    wr0 = wr_cnt;
    start_c();
    send_byte(8'hE0, 1'b0, "mb_addr_ack");
    send_byte(8'h01, 1'b0, "mb_d0_ack");
    send_byte(8'h06, 1'b0, "mb_d1_ack");
    stop_c();
    wclk(10);
    check("mb_chsel", 32'(chsel), 32'h6);
    check("mb_wrstb_cnt", 32'(wr_cnt - wr0), 32'd2);

    start_c();
    send_byte(8'hE0, 1'b0, "rs_addr_ack");
    send_byte(8'h03, 1'b0, "rs_data_ack");
    start_c();
    send_byte(8'hE1, 1'b0, "rs_raddr_ack");
    check("rs_busy", 32'(busy), 32'd1);
    recv_byte(8'h03, 1'b0, "rs_rd0");
    recv_byte(8'h03, 1'b1, "rs_rd1");
    check("rs_busy_nack", 32'(busy), 32'd0);
    stop_c();
    wclk(10);
    check("rs_chsel", 32'(chsel), 32'h3);

    wr0 = wr_cnt;
    start_c();
    send_byte(8'hE0, 1'b0, "ab_addr_ack");
    for (int i = 0; i < 4; i++) wbit(1'b1);
    stop_c();
    wclk(10);
    check("ab_chsel", 32'(chsel), 32'h3);
    check("ab_wrstb_cnt", 32'(wr_cnt - wr0), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    start_c();
    send_byte(8'hE1, 1'b0, "ab_idle_addr_ack");
    recv_byte(8'h03, 1'b1, "ab_idle_rd");
    stop_c();
    wclk(10);

    start_c();
    send_byte(8'hE1, 1'b0, "rr_addr_ack");
    check("rr_msb_drive", 32'(sdaoe), 32'd0);
    rst = 1'b1;
    wclk(1);
    check("rr_sdaoe", 32'(sdaoe), 32'd1);
    check("rr_chsel", 32'(chsel), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wclk(10);
    stop_c();
    wclk(20);

    st0 = n_start;
    msda = 1'b0;
    wclk(2);
    msda = 1'b1;
    wclk(20);
    check("gl_short_no_start", 32'(n_start - st0), 32'd0);
    st0 = n_start;
    msda = 1'b0;
    wclk(5);
    msda = 1'b1;
    wclk(20);
    check("gl_long_start", 32'(n_start - st0), 32'd1);
    check("gl_busy", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
